alu_core: RTL and testbench

Parametrised, sequential successor to the single-function 20-bit ALU circuits (logic, shift/rotate, compare). It merges them into one opcode-driven unit with valid/ready handshakes on both sides. It adds unsigned add/subtract and multi-bit shift/rotate by a run-time amount, executed one bit per cycle. Results and status flags (zero/sign/carry) are registered and held until consumed, so the block can feed a status register or pipeline stage directly.

---
 rtl/alu_core.sv | 156 +++++++++++++++
 tb/tb_alu_core.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Opcode-driven ALU with valid/ready handshakes on both sides. Shifts and rotates
// run one bit per cycle; results and zero/sign/carry flags are held until consumed.
module alu_core #(
  parameter int unsigned WIDTH   = 20,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               sign,
  output logic               carry
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [SHAMT_W-1:0] CntOne = SHAMT_W'(1);

  state_e             state_q, state_d;
  logic [1:0]         sh_op_q, sh_op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               sign_q, sign_d;
  logic               carry_q, carry_d;

  logic               accept;
  logic               is_shift_op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   imm_res;
  logic               imm_carry;
  logic               imm_cmp;
  logic [WIDTH-1:0]   step_res;
  logic               step_carry;

  assign in_ready    = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid   = (state_q == StDone);
  assign accept      = in_valid && in_ready;
  assign is_shift_op = (op[3:2] == 2'b01);

  assign result = result_q;
  assign zero   = zero_q;
  assign sign   = sign_q;
  assign carry  = carry_q;

  // Single-cycle result for everything except shifts/rotates with a non-zero amount.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    imm_res   = '0;
    imm_carry = 1'b0;
    imm_cmp   = 1'b0;
    case (op)
      4'd0:    imm_res = ~a;
      4'd1:    imm_res = a & b;
      4'd2:    imm_res = a | b;
      4'd3:    imm_res = a ^ b;
      4'd4, 4'd5, 4'd6, 4'd7: imm_res = a;
      4'd8:    begin imm_res = {{(WIDTH-1){1'b0}}, a == b}; imm_cmp = 1'b1; end
      4'd9:    begin imm_res = {{(WIDTH-1){1'b0}}, a > b};  imm_cmp = 1'b1; end
      4'd10:   begin imm_res = {{(WIDTH-1){1'b0}}, a < b};  imm_cmp = 1'b1; end
      4'd11:   begin imm_res = {{(WIDTH-1){1'b0}}, a >= b}; imm_cmp = 1'b1; end
      4'd12:   begin imm_res = {{(WIDTH-1){1'b0}}, a <= b}; imm_cmp = 1'b1; end
      4'd13:   begin imm_res = sum[WIDTH-1:0];  imm_carry = sum[WIDTH];  end
      4'd14:   begin imm_res = diff[WIDTH-1:0]; imm_carry = diff[WIDTH]; end
      default: imm_res = '0;
    endcase
  end

  // One bit of shift/rotate per cycle; carry is the bit that falls off the end.
  always_comb begin
    step_res   = work_q;
    step_carry = 1'b0;
    unique case (sh_op_q)
      2'b00: begin step_res = {1'b0, work_q[WIDTH-1:1]};     step_carry = work_q[0];       end
      2'b01: begin step_res = {work_q[WIDTH-2:0], 1'b0};     step_carry = work_q[WIDTH-1]; end
      2'b10: step_res = {work_q[0], work_q[WIDTH-1:1]};
      2'b11: step_res = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      default: step_res = work_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sh_op_d  = sh_op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    carry_d  = carry_q;

    if (state_q == StShift) begin
      work_d = step_res;
      cnt_d  = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        state_d  = StDone;
        result_d = step_res;
        zero_d   = (step_res == '0);
        sign_d   = step_res[WIDTH-1];
        carry_d  = step_carry;
      end
    end else begin
      if ((state_q == StDone) && out_ready) begin
        state_d = StIdle;
      end
      if (accept) begin
        if (is_shift_op && (shamt != '0)) begin
          state_d = StShift;
          sh_op_d = op[1:0];
          work_d  = a;
          cnt_d   = shamt;
        end else begin
          state_d  = StDone;
          result_d = imm_res;
          zero_d   = imm_cmp ? (a == b) : (imm_res == '0);
          sign_d   = imm_cmp ? (a < b) : imm_res[WIDTH-1];
          carry_d  = imm_carry;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sh_op_q  <= 2'b00;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_op_q  <= sh_op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      carry_q  <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: an arithmetic reference model with a per-cycle
// scoreboard, plus literal expectations for the headline vectors.
module tb_alu_core;

  localparam int W  = 20;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [SW-1:0] shamt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          sign;
  logic          carry;

  alu_core #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .sign      (sign),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         s;
    logic         c;
    int           due;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour from the opcode table, using plain arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input int sh);
    exp_t       e;
    logic [W:0] t;
    int         k;
    e.res = '0;
    e.c   = 1'b0;
    e.due = 0;
    case (o)
      4'd0: e.res = ~x;
      4'd1: e.res = x & y;
      4'd2: e.res = x | y;
      4'd3: e.res = x ^ y;
      4'd4: begin
        if (sh == 0) e.res = x;
        else if (sh > W) e.res = '0;
        else begin e.res = x >> sh; e.c = x[sh-1]; end
      end
      4'd5: begin
        if (sh == 0) e.res = x;
        else if (sh > W) e.res = '0;
        else begin e.res = x << sh; e.c = x[W-sh]; end
      end
      4'd6: begin
        k = sh % W;
        e.res = (k == 0) ? x : ((x >> k) | (x << (W - k)));
      end
      4'd7: begin
        k = sh % W;
        e.res = (k == 0) ? x : ((x << k) | (x >> (W - k)));
      end
      4'd8:  e.res = (x == y) ? 1 : 0;
      4'd9:  e.res = (x > y) ? 1 : 0;
      4'd10: e.res = (x < y) ? 1 : 0;
      4'd11: e.res = (x >= y) ? 1 : 0;
      4'd12: e.res = (x <= y) ? 1 : 0;
      4'd13: begin t = {1'b0, x} + {1'b0, y}; e.res = t[W-1:0]; e.c = t[W]; end
      4'd14: begin e.res = x - y; e.c = (x < y); end
      default: e.res = '0;
    endcase
    if (o >= 4'd8 && o <= 4'd12) begin
      e.z = (x == y);
      e.s = (x < y);
    end else begin
      e.z = (e.res == '0);
      e.s = e.res[W-1];
    end
    return e;
  endfunction

  // Scoreboard: inputs are driven just after posedge, everything is sampled at negedge.
  logic mon_ev;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result", result, 0);
      chk("rst_flags", {zero, sign, carry}, 0);
      q.delete();
    end else begin
      mon_ev = (q.size() > 0) && (cyc >= q[0].due);
      chk("out_valid", out_valid, mon_ev);
      chk("in_ready", in_ready, (q.size() == 0) || (mon_ev && out_ready));
      if (mon_ev && out_valid) begin
        chk("result", result, q[0].res);
        chk("zero", zero, q[0].z);
        chk("sign", sign, q[0].s);
        chk("carry", carry, q[0].c);
      end
      if (mon_ev && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) begin
        mon_e = model(op, a, b, int'(shamt));
        mon_e.due = cyc + 1 + ((op >= 4'd4 && op <= 4'd7) ? int'(shamt) : 0);
        q.push_back(mon_e);
      end
    end
  end

  // Present a request and hold it until accepted; returns at posedge+1 after the accept.
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [SW-1:0] sh);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    op = o; a = x; b = y; shamt = sh; in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    // Scramble inputs after capture; the DUT must ignore them.
    a = W'($urandom); b = W'($urandom); shamt = SW'($urandom); op = 4'($urandom);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic expect_lit(input string nm, input logic [W-1:0] r, input logic z,
                            input logic s, input logic c, input int lat);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_result"}, result, r);
    chk({nm, "_flags"}, {zero, sign, carry}, {z, s, c});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  typedef struct packed {
    logic [3:0]    o;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [SW-1:0] s;
  } vec_t;

  vec_t vecs[14] = '{
    '{4'd4,  20'h80000, 20'h00000, 5'd20},
    '{4'd4,  20'hABCDE, 20'h00000, 5'd25},
    '{4'd5,  20'h00001, 20'h00000, 5'd19},
    '{4'd5,  20'hC0000, 20'h00000, 5'd1},
    '{4'd6,  20'h00001, 20'h00000, 5'd1},
    '{4'd6,  20'h12345, 20'h00000, 5'd20},
    '{4'd7,  20'h12345, 20'h00000, 5'd0},
    '{4'd8,  20'h00005, 20'h00005, 5'd3},
    '{4'd11, 20'h00003, 20'h00004, 5'd0},
    '{4'd12, 20'h00009, 20'h00004, 5'd0},
    '{4'd15, 20'hFFFFF, 20'h12345, 5'd7},
    '{4'd13, 20'h7FFFF, 20'h00001, 5'd0},
    '{4'd2,  20'hF0000, 20'h0000F, 5'd0},
    '{4'd9,  20'h00003, 20'h00005, 5'd0}
  };

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(4'd13, 20'hFFFFF, 20'h00001, 5'd0);
    expect_lit("add", 20'h00000, 1'b1, 1'b0, 1'b1, 1);
    do_op(4'd14, 20'h00003, 20'h00005, 5'd0);
    expect_lit("sub", 20'hFFFFE, 1'b0, 1'b1, 1'b1, 1);
    do_op(4'd4, 20'h00003, 20'h00000, 5'd2);
    expect_lit("shr", 20'h00000, 1'b1, 1'b0, 1'b1, 3);
    do_op(4'd7, 20'h80001, 20'h00000, 5'd21);
    expect_lit("rol", 20'h00003, 1'b0, 1'b0, 1'b0, 22);
    do_op(4'd9, 20'h00005, 20'h00003, 5'd0);
    expect_lit("gt", 20'h00001, 1'b0, 1'b0, 1'b0, 1);
    do_op(4'd12, 20'h00007, 20'h00007, 5'd0);
    expect_lit("le", 20'h00001, 1'b1, 1'b0, 1'b0, 1);
    do_op(4'd10, 20'h00002, 20'h00009, 5'd0);
    expect_lit("lt", 20'h00001, 1'b0, 1'b1, 1'b0, 1);

    // Issued back to back; the scoreboard checks every result and its timing.
    foreach (vecs[i]) do_op(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].s);
    wait_drain();

    // Backpressure, then consume and accept on the same edge.
    out_ready = 1'b0;
    do_op(4'd3, 20'h12345, 20'h0F0F0, 5'd0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 20'h1D3B5);
      chk("bp_flags", {zero, sign, carry}, 3'b000);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    do_op(4'd1, 20'hFF00F, 20'h0FFF0, 5'd0);
    expect_lit("and", 20'h0F000, 1'b0, 1'b0, 1'b0, 1);
    wait_drain();

    // Plain reset pulse, then idle with no request.
    do_op(4'd0, 20'h00000, 20'h00000, 5'd0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Reset in the middle of a long shift: that result must never appear.
    do_op(4'd5, 20'h00001, 20'h00000, 5'd15);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    do_op(4'd0, 20'h0F0F0, 20'h00000, 5'd0);
    expect_lit("not", 20'hF0F0F, 1'b0, 1'b1, 1'b0, 1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
